// File: rtl/door_input_conditioner.sv
// Input conditioning for the garage door controller: synchronises and debounces the
// push-button and both limit switches, then turns the clean button into a one-cycle Activate.
module door_input_conditioner #(
  parameter int DB_CNT    = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic Btn_raw,
  input  logic Up_sw_raw,
  input  logic Dn_sw_raw,
  output logic Activate,
  output logic UP_Max,
  output logic DN_Max,
  output logic Sw_fault
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DB_CNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Channel index: 0 = button, 1 = upper limit, 2 = lower limit
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] stable_q, stable_d;
  logic [CNT_WIDTH-1:0] cnt_q [3];
  logic [CNT_WIDTH-1:0] cnt_d [3];

  logic btn_prev_q, btn_prev_d;
  logic armed_q, armed_d;
  logic activate_q, activate_d;
  logic sw_fault_q, sw_fault_d;
  logic btn_rise;

  assign raw = {Dn_sw_raw, Up_sw_raw, Btn_raw};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end

    btn_prev_d = stable_q[0];
    btn_rise   = stable_q[0] & ~btn_prev_q;
    armed_d    = armed_q | ~stable_q[0];
    sw_fault_d = stable_q[1] & stable_q[2];
    // A press seen while the limits disagree is dropped outright, never replayed later
    activate_d = btn_rise & armed_q & ~sw_fault_q & ~sw_fault_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      btn_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      activate_q <= 1'b0;
      sw_fault_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
      activate_q <= activate_d;
      sw_fault_q <= sw_fault_d;
    end
  end

  assign Activate = activate_q;
  assign UP_Max   = stable_q[1];
  assign DN_Max   = stable_q[2];
  assign Sw_fault = sw_fault_q;

endmodule
